// File: rtl/arb_pkg.sv
// Shared types and default sizing for the output-port arbiter and its bench.
package arb_pkg;
    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_MAX_HOLD = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Index width that stays legal for a single-entry range.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/out_port_arbiter_if.sv
// Request/grant bundle between the requesting ports and the output-port arbiter.
interface out_port_arbiter_if
    import arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);
    localparam int IDW = idw(NUM_REQ);

    // A port raises req and holds it for the whole packet; eop marks the last
    // beat and only counts while that port is granted. gnt is one-hot and
    // registered; a beat transfers on every cycle where req and gnt agree.
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] eop;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [IDW-1:0]     gnt_id;
    logic               timeout_err;

    modport master (
        output req, eop,
        input  gnt, gnt_valid, gnt_id, timeout_err
    );

    modport slave (
        input  req, eop,
        output gnt, gnt_valid, gnt_id, timeout_err
    );
endinterface

// File: rtl/out_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_id.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDW    = idw(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_id,
    output logic               found,
    output logic [IDW-1:0]     winner_id
);
    logic [IDW-1:0] idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        found     = 1'b0;
        winner_id = '0;
        idx       = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = IDW'((int'(last_id) + i) % NUM_REQ);
            if (req[idx]) begin
                found     = 1'b1;
                winner_id = idx;
            end
        end
    end
endmodule

// File: rtl/out_port_arbiter.sv
// Packet-level round-robin arbiter for one output port with a hold timeout.
module out_port_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                clk,
    input  logic                reset,
    out_port_arbiter_if.slave   bus,
    output state_t              fsm_state
);
    localparam int IDW = idw(NUM_REQ);
    localparam int HW  = idw(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t         state;
    logic [HW-1:0]  hold_cnt;
    logic [IDW-1:0] last_id;
    logic           found;
    logic [IDW-1:0] winner;
    logic           g_req;
    logic           g_eop;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req       (bus.req),
        .last_id   (last_id),
        .found     (found),
        .winner_id (winner)
    );

    assign g_req     = bus.req[bus.gnt_id];
    assign g_eop     = bus.eop[bus.gnt_id];
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            bus.gnt         <= '0;
            bus.gnt_valid   <= 1'b0;
            bus.gnt_id      <= '0;
            bus.timeout_err <= 1'b0;
            hold_cnt        <= '0;
            last_id         <= IDW'(NUM_REQ - 1);
        end else begin
            bus.timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state         <= GRANT;
                        bus.gnt       <= NUM_REQ'(1) << winner;
                        bus.gnt_valid <= 1'b1;
                        bus.gnt_id    <= winner;
                        hold_cnt      <= '0;
                    end
                end
                GRANT: begin
                    // eop or an abandoned packet takes priority over the timeout.
                    if (!g_req || g_eop || hold_cnt == HOLD_LAST) begin
                        state           <= RELEASE;
                        bus.gnt         <= '0;
                        bus.gnt_valid   <= 1'b0;
                        bus.gnt_id      <= '0;
                        last_id         <= bus.gnt_id;
                        bus.timeout_err <= g_req && !g_eop;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: vector table plus multi-cycle sequences.
module tb_out_port_arbiter;
  import arb_pkg::*;

  localparam int N = DEF_NUM_REQ;

  logic   clk;
  logic   reset;
  state_t st;
  int     total;
  int     bad;
  bit     mon_en;

  out_port_arbiter_if #(.NUM_REQ(N)) bus();

  out_port_arbiter #(.NUM_REQ(N), .MAX_HOLD(DEF_MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .fsm_state (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] eop;
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] id;
    logic       to;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Structural invariants on every sampled cycle once out of initial reset.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
      chk("valid_vs_gnt", 32'(bus.gnt_valid), 32'(|bus.gnt));
    end
  end

  task automatic do_reset();
    reset   = 1'b0;
    bus.req = '0;
    bus.eop = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_gnt", 32'(bus.gnt), 32'd0);
    reset = 1'b1;
  endtask

  task automatic wait_grant(input int max, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (bus.gnt_valid) begin
        ok = 1'b1;
        break;
      end
      cycles++;
    end
  endtask

  int  cyc;
  bit  ok;
  int  cnt;
  bit  early_to;
  logic [3:0] exp_g;

  initial begin
    total   = 0;
    bad     = 0;
    mon_en  = 1'b0;
    reset   = 1'b0;
    bus.req = '0;
    bus.eop = '0;

    //             rst  req      eop      gnt      vld   id     to
    vecs[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[3]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[4]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[5]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[6]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[8]  = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[9]  = '{1'b1, 4'b0110, 4'b0100, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[10] = '{1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[11] = '{1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[12] = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[13] = '{1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[14] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[15] = '{1'b1, 4'b1001, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0};
    vecs[16] = '{1'b1, 4'b1001, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0};
    vecs[17] = '{1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[18] = '{1'b1, 4'b1001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
    vecs[19] = '{1'b1, 4'b1001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[20] = '{1'b1, 4'b1001, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[21] = '{1'b1, 4'b1001, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0};
    vecs[22] = '{1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[23] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};

    @(negedge clk);
    for (int v = 0; v < 24; v++) begin
      reset   = vecs[v].rst_n;
      bus.req = vecs[v].req;
      bus.eop = vecs[v].eop;
      @(posedge clk);
      @(negedge clk);
      mon_en = 1'b1;
      total++;
      if (bus.gnt !== vecs[v].gnt || bus.gnt_valid !== vecs[v].vld ||
          bus.gnt_id !== vecs[v].id || bus.timeout_err !== vecs[v].to) begin
        bad++;
        $display("FAIL vec%0d: got gnt=%b vld=%b id=%0d to=%b want gnt=%b vld=%b id=%0d to=%b",
                 v, bus.gnt, bus.gnt_valid, bus.gnt_id, bus.timeout_err,
                 vecs[v].gnt, vecs[v].vld, vecs[v].id, vecs[v].to);
      end
    end

    // Round robin with all ports requesting; eop on the 4th granted beat.
    do_reset();
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(10, cyc, ok);
      chk("rr_grant_seen", 32'(ok), 32'd1);
      chk("rr_gap", 32'(cyc), (g == 0) ? 32'd0 : 32'd1);
      exp_g = 4'(1 << (g % 4));
      chk("rr_id", 32'(bus.gnt_id), 32'(g % 4));
      chk("rr_gnt", 32'(bus.gnt), 32'(exp_g));
      for (int b = 2; b <= 4; b++) begin
        @(negedge clk);
        chk("rr_hold", 32'(bus.gnt), 32'(exp_g));
      end
      bus.eop = exp_g;
      @(negedge clk);
      bus.eop = '0;
      chk("rr_release", 32'(bus.gnt), 32'd0);
    end
    bus.req = '0;
    @(negedge clk);

    // Timeout: port 2 alone, never sends eop.
    do_reset();
    bus.req = 4'b0100;
    wait_grant(10, cyc, ok);
    chk("to_grant_seen", 32'(ok), 32'd1);
    cnt      = 0;
    early_to = 1'b0;
    while (bus.gnt == 4'b0100 && cnt < 100) begin
      if (bus.timeout_err) early_to = 1'b1;
      cnt++;
      @(negedge clk);
    end
    chk("to_early", 32'(early_to), 32'd0);
    chk("to_hold_len", 32'(cnt), 32'd64);
    chk("to_pulse", 32'(bus.timeout_err), 32'd1);
    chk("to_release_gnt", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    chk("to_pulse_end", 32'(bus.timeout_err), 32'd0);
    chk("to_idle_gnt", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    chk("to_regrant", 32'(bus.gnt), 32'b0100);
    bus.req = '0;
    @(negedge clk);
    chk("to_abandon", 32'(bus.gnt), 32'd0);
    @(negedge clk);

    // eop on hold cycle 63 beats the timeout.
    do_reset();
    bus.req = 4'b0010;
    wait_grant(10, cyc, ok);
    chk("eop63_grant_seen", 32'(ok), 32'd1);
    for (int b = 1; b < 64; b++) @(negedge clk);
    chk("eop63_still_granted", 32'(bus.gnt), 32'b0010);
    bus.eop = 4'b0010;
    @(negedge clk);
    bus.eop = '0;
    bus.req = '0;
    chk("eop63_release", 32'(bus.gnt), 32'd0);
    chk("eop63_no_to", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    chk("eop63_no_to_late", 32'(bus.timeout_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
